rob_2way: RTL

Two-wide reorder buffer for the R10000-style out-of-order core. It allocates entries in program order at dispatch, marks them complete from the two CDB lanes, and retires up to two completed instructions per cycle in order. At retire it hands the stale physical register (Told) to the free list. On branch rollback it squashes all younger entries and supplies the free-list tail snapshot that restores the free list.

---
 rtl/rob_2way_if.sv | 52 +++++
 rtl/rob_2way.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rob_2way_if.sv
// Dispatch / completion / rollback / retire bundle between the core and the
// two-wide reorder buffer. The core drives through the master modport and the
// ROB sits on the slave side.
interface rob_2way_if #(
    parameter int NUM_ROB = 32,
    parameter int PR_W    = 6,
    parameter int AR_W    = 5,
    parameter int FL_W    = 5
);
    localparam int IDX_W = $clog2(NUM_ROB);
    localparam int CNT_W = IDX_W + 1;

    // dispatch side, slot 0 is the older instruction
    logic                   dispatch_en;
    logic [1:0]             dispatch_valid;
    logic [2*AR_W-1:0]      dest_idx;
    logic [2*PR_W-1:0]      T_idx;
    logic [2*PR_W-1:0]      Told_idx;
    logic [2*FL_W-1:0]      FL_idx;
    logic                   ROB_valid;
    logic [2*IDX_W-1:0]     rob_idx;

    // two completion lanes from the CDB
    logic [1:0]             cdb_valid;
    logic [2*IDX_W-1:0]     cdb_rob_idx;

    // branch misprediction recovery
    logic                   rollback_en;
    logic [IDX_W-1:0]       rollback_rob_idx;
    logic [FL_W-1:0]        FL_rollback_idx;

    // in-order retirement
    logic [1:0]             retire_en;
    logic [2*AR_W-1:0]      retire_dest_idx;
    logic [2*PR_W-1:0]      retire_T_idx;
    logic [2*PR_W-1:0]      retire_Told_idx;
    logic [CNT_W-1:0]       count;

    modport master (
        output dispatch_en, dispatch_valid, dest_idx, T_idx, Told_idx, FL_idx,
        output cdb_valid, cdb_rob_idx, rollback_en, rollback_rob_idx,
        input  ROB_valid, rob_idx, FL_rollback_idx,
        input  retire_en, retire_dest_idx, retire_T_idx, retire_Told_idx, count
    );

    modport slave (
        input  dispatch_en, dispatch_valid, dest_idx, T_idx, Told_idx, FL_idx,
        input  cdb_valid, cdb_rob_idx, rollback_en, rollback_rob_idx,
        output ROB_valid, rob_idx, FL_rollback_idx,
        output retire_en, retire_dest_idx, retire_T_idx, retire_Told_idx, count
    );
endinterface

// File: rtl/rob_2way.sv
// Two-wide reorder buffer: allocates up to two entries per cycle in program
// order, marks them complete from two CDB lanes, retires up to two completed
// entries per cycle in order and squashes younger entries on branch rollback.
// Occupancy is tracked by an explicit counter; head==tail is ambiguous and is
// never used to tell full from empty.
module rob_2way #(
    parameter int NUM_ROB = 32,
    parameter int PR_W    = 6,
    parameter int AR_W    = 5,
    parameter int FL_W    = 5
) (
    input  logic       clock,
    input  logic       reset,
    rob_2way_if.slave  rif
);
    localparam int IDX_W = $clog2(NUM_ROB);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(NUM_ROB - 2);

    // number of set bits in a two-bit slot mask
    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    // pointers and occupancy
    logic [IDX_W-1:0] head_r;
    logic [IDX_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             rob_valid_r;

    // per-entry state
    logic [NUM_ROB-1:0] valid_r;
    logic [NUM_ROB-1:0] complete_r;
    logic [AR_W-1:0]    dest_r [NUM_ROB];
    logic [PR_W-1:0]    t_r    [NUM_ROB];
    logic [PR_W-1:0]    told_r [NUM_ROB];
    logic [FL_W-1:0]    fl_r   [NUM_ROB];

    // derived control
    logic [IDX_W-1:0] head_p1_s;
    logic [IDX_W-1:0] slot1_idx_s;
    logic [IDX_W-1:0] cdb0_idx_s;
    logic [IDX_W-1:0] cdb1_idx_s;
    logic [IDX_W-1:0] roll_off_s;
    logic             dispatch_fire_s;
    logic             ret0_s;
    logic             ret1_s;
    logic [1:0]       retired_cnt_s;
    logic [1:0]       dispatched_cnt_s;
    logic [CNT_W-1:0] count_next_s;

    logic [NUM_ROB-1:0] cpl_hit_s;
    logic [NUM_ROB-1:0] ret_clr_s;
    logic [NUM_ROB-1:0] squash_s;
    logic [NUM_ROB-1:0] wr0_s;
    logic [NUM_ROB-1:0] wr1_s;

    assign head_p1_s   = head_r + IDX_ONE;
    assign slot1_idx_s = tail_r + {{(IDX_W-1){1'b0}}, rif.dispatch_valid[0]};
    assign cdb0_idx_s  = rif.cdb_rob_idx[IDX_W-1:0];
    assign cdb1_idx_s  = rif.cdb_rob_idx[2*IDX_W-1:IDX_W];
    // distance of the surviving branch from head, in program order
    assign roll_off_s  = rif.rollback_rob_idx - head_r;

    assign dispatch_fire_s = rif.dispatch_en & rob_valid_r & ~rif.rollback_en;

    // Retire selection; when the branch being rolled back sits at head, the
    // entry behind it is squashed and must not retire alongside it.
    always_comb begin
        ret0_s = valid_r[head_r] & complete_r[head_r];
        if (rif.rollback_en && (rif.rollback_rob_idx == head_r)) begin
            ret1_s = 1'b0;
        end else begin
            ret1_s = ret0_s & valid_r[head_p1_s] & complete_r[head_p1_s];
        end
    end

    assign retired_cnt_s    = pop2({ret1_s, ret0_s});
    assign dispatched_cnt_s = dispatch_fire_s ? pop2(rif.dispatch_valid) : 2'b00;

    // Next occupancy; on rollback the survivors are head..branch inclusive.
    // The sum is kept in the wider count width so a full-ROB rollback at the
    // youngest entry yields NUM_ROB rather than wrapping to zero.
    always_comb begin
        if (rif.rollback_en) begin
            count_next_s = CNT_W'(roll_off_s) + CNT_ONE
                         - {{(CNT_W-2){1'b0}}, retired_cnt_s};
        end else begin
            count_next_s = count_r
                         + {{(CNT_W-2){1'b0}}, dispatched_cnt_s}
                         - {{(CNT_W-2){1'b0}}, retired_cnt_s};
        end
    end

    // Per-entry decode of writes, completions, retirement clears and squashes.
    always_comb begin
        cpl_hit_s = '0;
        ret_clr_s = '0;
        squash_s  = '0;
        wr0_s     = '0;
        wr1_s     = '0;
        for (int i = 0; i < NUM_ROB; i++) begin
            cpl_hit_s[i] = valid_r[i]
                         & ((rif.cdb_valid[0] & (cdb0_idx_s == IDX_W'(i)))
                          | (rif.cdb_valid[1] & (cdb1_idx_s == IDX_W'(i))));
            ret_clr_s[i] = (ret0_s & (head_r == IDX_W'(i)))
                         | (ret1_s & (head_p1_s == IDX_W'(i)));
            squash_s[i]  = rif.rollback_en
                         & ((IDX_W'(i) - head_r) > roll_off_s);
            wr0_s[i]     = dispatch_fire_s & rif.dispatch_valid[0]
                         & (tail_r == IDX_W'(i));
            wr1_s[i]     = dispatch_fire_s & rif.dispatch_valid[1]
                         & (slot1_idx_s == IDX_W'(i));
        end
    end

    // Entry storage: allocation, completion, retirement and squash.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r    <= '0;
            complete_r <= '0;
            for (int i = 0; i < NUM_ROB; i++) begin
                dest_r[i] <= '0;
                t_r[i]    <= '0;
                told_r[i] <= '0;
                fl_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ROB; i++) begin
                if (wr0_s[i]) begin
                    valid_r[i]    <= 1'b1;
                    complete_r[i] <= 1'b0;
                    dest_r[i]     <= rif.dest_idx[AR_W-1:0];
                    t_r[i]        <= rif.T_idx[PR_W-1:0];
                    told_r[i]     <= rif.Told_idx[PR_W-1:0];
                    fl_r[i]       <= rif.FL_idx[FL_W-1:0];
                end else if (wr1_s[i]) begin
                    valid_r[i]    <= 1'b1;
                    complete_r[i] <= 1'b0;
                    dest_r[i]     <= rif.dest_idx[2*AR_W-1:AR_W];
                    t_r[i]        <= rif.T_idx[2*PR_W-1:PR_W];
                    told_r[i]     <= rif.Told_idx[2*PR_W-1:PR_W];
                    fl_r[i]       <= rif.FL_idx[2*FL_W-1:FL_W];
                end else if (ret_clr_s[i] || squash_s[i]) begin
                    valid_r[i]    <= 1'b0;
                    complete_r[i] <= 1'b0;
                end else if (cpl_hit_s[i]) begin
                    complete_r[i] <= 1'b1;
                end else begin
                    complete_r[i] <= complete_r[i];
                end
            end
        end
    end

    // Head, tail, occupancy and the registered space-available flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            rob_valid_r <= 1'b1;
        end else begin
            head_r <= head_r + {{(IDX_W-2){1'b0}}, retired_cnt_s};
            if (rif.rollback_en) begin
                tail_r <= rif.rollback_rob_idx + IDX_ONE;
            end else begin
                tail_r <= tail_r + {{(IDX_W-2){1'b0}}, dispatched_cnt_s};
            end
            count_r     <= count_next_s;
            rob_valid_r <= (count_next_s <= CNT_LIMIT);
        end
    end

    assign rif.ROB_valid       = rob_valid_r;
    assign rif.count           = count_r;
    assign rif.rob_idx         = {slot1_idx_s, tail_r};
    assign rif.retire_en       = {ret1_s, ret0_s};
    assign rif.FL_rollback_idx = fl_r[rif.rollback_rob_idx];

    // retire fields read zero on a slot that is not retiring
    assign rif.retire_dest_idx = {ret1_s ? dest_r[head_p1_s] : {AR_W{1'b0}},
                                  ret0_s ? dest_r[head_r]    : {AR_W{1'b0}}};
    assign rif.retire_T_idx    = {ret1_s ? t_r[head_p1_s]    : {PR_W{1'b0}},
                                  ret0_s ? t_r[head_r]       : {PR_W{1'b0}}};
    assign rif.retire_Told_idx = {ret1_s ? told_r[head_p1_s] : {PR_W{1'b0}},
                                  ret0_s ? told_r[head_r]    : {PR_W{1'b0}}};
endmodule
